clock_time_counter: RTL and testbench
=====================================

Name: clock_time_counter

Overview:
- Time-keeping core of the Clock design: divides the board clock down to a 1 Hz tick and keeps a 24-hour HH:MM:SS count in BCD.
- Produces six 4-bit BCD digits, one per display position.
- Each digit drives one seven-segment decoder instance directly downstream.
- Accepts one-cycle-clean minute/hour set inputs; debouncing and synchronisation are done upstream.

Parameters:
CLK_FREQ, 50000000, input clock cycles per second; prescaler terminal count is CLK_FREQ-1; must be >= 2.

Ports:
CLK  input  1  system clock, all logic on rising edge
RST_N  input  1  asynchronous active-low reset
RUN  input  1  1 = time advances; 0 = prescaler and time frozen
INC_MIN  input  1  level, synchronous to CLK; each rising edge advances minutes
INC_HOUR  input  1  level, synchronous to CLK; each rising edge advances hours
TICK  output  1  one-cycle pulse when the 1 Hz tick is applied
SEC_ONES  output  4  BCD seconds units, 0-9
SEC_TENS  output  4  BCD seconds tens, 0-5
MIN_ONES  output  4  BCD minutes units, 0-9
MIN_TENS  output  4  BCD minutes tens, 0-5
HOUR_ONES  output  4  BCD hours units, 0-9 (0-3 when HOUR_TENS=2)
HOUR_TENS  output  4  BCD hours tens, 0-2

Behaviour:
- Reset (RST_N low, asynchronous):
  - All outputs = 0, i.e. time 00:00:00, TICK=0.
  - Prescaler = 0.
  - Edge-detect registers for INC_MIN and INC_HOUR = 0.
- All outputs are registered; no combinational path from any input to any output.
- Prescaler:
  - Width is ceil(log2(CLK_FREQ)).
  - With RUN=1 it counts 0..CLK_FREQ-1 and wraps to 0.
  - With RUN=0 it holds its value.
- Tick condition: RUN=1 and prescaler = CLK_FREQ-1.
  - TICK goes high for exactly the following cycle.
  - Time digits update on the same edge TICK rises, so their latency matches TICK.
- Button edges:
  - Registered copies of INC_MIN and INC_HOUR are kept.
  - Edge = input high AND registered copy low.
  - Holding a button high produces only one edge.
  - Edges are honoured regardless of RUN.
- Tick update, applied when no minute edge is present:
  - Seconds advance 00..59; at 59 they wrap to 00 and carry into minutes.
  - Minutes advance 00..59; at 59 they wrap to 00 and carry into hours.
  - Hours advance 00..23; at 23 they wrap to 00.
  - BCD rule: a ones digit of 9 wraps to 0 and increments its tens digit.
- Minute edge:
  - MIN_ONES/MIN_TENS advance by one mod 60, with no carry into hours.
  - SEC_ONES/SEC_TENS and the prescaler clear to 0.
  - A tick in the same cycle is discarded and TICK stays 0.
- Hour edge: hours advance by one mod 24; minutes and seconds are unaffected.
- Same-cycle hour edge and tick carry into hours: hours increment once only, never twice.
  - Example: 23:59:59 + tick + INC_HOUR edge -> 00:00:00.
- Both button edges in the same cycle: both apply. Minutes +1 mod 60, seconds clear, tick dropped, hours +1 mod 24.
- Digit values are never outside their legal BCD range; no illegal state is reachable after reset.
- Reset mid-count: the asynchronous clear takes effect immediately. The next tick arrives CLK_FREQ cycles after reset release with RUN=1.

Test Plan:
- Run from reset (CLK_FREQ=4, RUN=1) -> first TICK 4 cycles after reset release, then every 4 cycles; SEC_ONES steps 0->1->2; after 10 ticks SEC_TENS=1, SEC_ONES=0.
- Preload 23:59:59 via button edges and ticks, then one tick -> all six digits 0 and TICK pulses once; 09:59:59 + tick -> HOUR_TENS=1, HOUR_ONES=0, minutes and seconds 00.
- Freeze: RUN=0 for 20 cycles mid-second -> digits and prescaler unchanged, no TICK; RUN=1 -> tick resumes after the remaining prescaler count.
- Set buttons:
  - INC_MIN held high 10 cycles at 12:59:37 -> exactly one edge; time becomes 12:00:00.
  - INC_HOUR pulse at 23:10:05 -> 00:10:05.
- Collisions:
  - INC_MIN edge on a tick cycle at 00:05:30 -> 00:06:00 with TICK=0.
  - INC_HOUR edge on the tick at 22:59:59 -> 23:00:00, not 00:00:00.
- Reset asserted asynchronously mid-prescaler at 14:27:08 -> outputs 0 within the same cycle, no clock edge required; normal counting resumes after release.

Source files
------------

// File: rtl/clock_time_counter_if.sv
// Control inputs and BCD time outputs of the clock time-keeping core.
// Six 4-bit digits feed the downstream seven-segment decoders.
interface clock_time_counter_if;
  logic       RUN;
  logic       INC_MIN;
  logic       INC_HOUR;
  logic       TICK;
  logic [3:0] SEC_ONES;
  logic [3:0] SEC_TENS;
  logic [3:0] MIN_ONES;
  logic [3:0] MIN_TENS;
  logic [3:0] HOUR_ONES;
  logic [3:0] HOUR_TENS;

  modport master (
    output RUN, INC_MIN, INC_HOUR,
    input  TICK, SEC_ONES, SEC_TENS, MIN_ONES, MIN_TENS, HOUR_ONES, HOUR_TENS
  );

  modport slave (
    input  RUN, INC_MIN, INC_HOUR,
    output TICK, SEC_ONES, SEC_TENS, MIN_ONES, MIN_TENS, HOUR_ONES, HOUR_TENS
  );
endinterface

// File: rtl/clock_time_counter.sv
// 1 Hz prescaler plus a 24-hour HH:MM:SS BCD counter with minute/hour set buttons.
// Every output comes straight from a register.
module clock_time_counter #(
  parameter int CLK_FREQ = 50000000
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  clock_time_counter_if.slave  bus
);

  localparam int            PW   = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] TERM = PW'(CLK_FREQ - 1);

  // Digit pairs are held as {tens, ones}.
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    sec_q, sec_d;
  logic [7:0]    min_q, min_d;
  logic [7:0]    hour_q, hour_d;
  logic          tick_q, tick_d;
  logic          inc_min_q, inc_hour_q;
  logic          min_edge, hour_edge, hour_carry;

  function automatic logic [7:0] inc_mod60(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) r = 8'h00;
      else                r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [7:0] inc_mod24(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h23)             r = 8'h00;
    else if (v[3:0] == 4'd9)    r = {v[7:4] + 4'd1, 4'd0};
    else                        r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  assign min_edge  = bus.INC_MIN  & ~inc_min_q;
  assign hour_edge = bus.INC_HOUR & ~inc_hour_q;

  always_comb begin
    presc_d    = presc_q;
    sec_d      = sec_q;
    min_d      = min_q;
    hour_d     = hour_q;
    tick_d     = 1'b0;
    hour_carry = 1'b0;
    if (min_edge) begin
      // A minute set restarts the current minute and swallows any pending tick.
      min_d   = inc_mod60(min_q);
      sec_d   = 8'h00;
      presc_d = '0;
    end else if (bus.RUN) begin
      if (presc_q == TERM) begin
        presc_d = '0;
        tick_d  = 1'b1;
        sec_d   = inc_mod60(sec_q);
        if (sec_q == 8'h59) begin
          min_d      = inc_mod60(min_q);
          hour_carry = (min_q == 8'h59);
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
    // Carry and hour button collapse into a single increment.
    if (hour_edge || hour_carry) hour_d = inc_mod24(hour_q);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc_q    <= '0;
      sec_q      <= 8'h00;
      min_q      <= 8'h00;
      hour_q     <= 8'h00;
      tick_q     <= 1'b0;
      inc_min_q  <= 1'b0;
      inc_hour_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      tick_q     <= tick_d;
      inc_min_q  <= bus.INC_MIN;
      inc_hour_q <= bus.INC_HOUR;
    end
  end

  assign bus.TICK      = tick_q;
  assign bus.SEC_ONES  = sec_q[3:0];
  assign bus.SEC_TENS  = sec_q[7:4];
  assign bus.MIN_ONES  = min_q[3:0];
  assign bus.MIN_TENS  = min_q[7:4];
  assign bus.HOUR_ONES = hour_q[3:0];
  assign bus.HOUR_TENS = hour_q[7:4];

endmodule

// File: tb/tb_clock_time_counter.sv
// Directed bench for clock_time_counter with a 4-cycle second.
module tb_clock_time_counter;
  logic CLK;
  logic RST_N;
  int   checks;
  int   failures;
  logic tick_seen;

  clock_time_counter_if bus ();

  clock_time_counter #(.CLK_FREQ(4)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [23:0] now();
    return {bus.HOUR_TENS, bus.HOUR_ONES, bus.MIN_TENS, bus.MIN_ONES,
            bus.SEC_TENS, bus.SEC_ONES};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic press_min();
    bus.INC_MIN = 1'b1; cyc(1);
    bus.INC_MIN = 1'b0; cyc(1);
  endtask

  task automatic press_hour();
    bus.INC_HOUR = 1'b1; cyc(1);
    bus.INC_HOUR = 1'b0; cyc(1);
  endtask

  // Leaves the counter at h:m:s with prescaler 0 and RUN=0.
  task automatic set_time(input int h, input int m, input int s);
    bus.RUN = 1'b0; bus.INC_MIN = 1'b0; bus.INC_HOUR = 1'b0;
    RST_N = 1'b0; #2; RST_N = 1'b1;
    for (int i = 0; i < h; i++) press_hour();
    for (int i = 0; i < m; i++) press_min();
    bus.RUN = 1'b1;
    cyc(4 * s);
    bus.RUN = 1'b0;
    cyc(1);
  endtask

  initial begin
    checks = 0; failures = 0;
    RST_N = 1'b0; bus.RUN = 1'b0; bus.INC_MIN = 1'b0; bus.INC_HOUR = 1'b0;
    cyc(2);
    chk("reset_time", 32'(now()), 32'h000000);
    chk("reset_tick", 32'(bus.TICK), 32'h0);

    // Run from reset
    RST_N = 1'b1; bus.RUN = 1'b1;
    cyc(3);
    chk("pre_first_tick", 32'(bus.TICK), 32'h0);
    cyc(1);
    chk("first_tick", 32'(bus.TICK), 32'h1);
    chk("first_tick_time", 32'(now()), 32'h000001);
    cyc(1);
    chk("tick_one_cycle", 32'(bus.TICK), 32'h0);
    cyc(3);
    chk("second_tick", 32'(bus.TICK), 32'h1);
    chk("second_tick_time", 32'(now()), 32'h000002);
    cyc(32);
    chk("ten_seconds", 32'(now()), 32'h000010);

    // Midnight wrap
    set_time(23, 59, 59);
    chk("preload_235959", 32'(now()), 32'h235959);
    bus.RUN = 1'b1;
    cyc(3);
    chk("hold_before_wrap", 32'(now()), 32'h235959);
    cyc(1);
    chk("midnight_wrap", 32'(now()), 32'h000000);
    chk("midnight_tick", 32'(bus.TICK), 32'h1);

    // Hour tens carry
    set_time(9, 59, 59);
    bus.RUN = 1'b1;
    cyc(4);
    chk("hour_tens_carry", 32'(now()), 32'h100000);

    // Freeze mid-second
    set_time(12, 34, 56);
    bus.RUN = 1'b1;
    cyc(2);
    bus.RUN = 1'b0;
    tick_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      tick_seen = tick_seen | bus.TICK;
    end
    chk("freeze_time", 32'(now()), 32'h123456);
    chk("freeze_no_tick", 32'(tick_seen), 32'h0);
    bus.RUN = 1'b1;
    cyc(1);
    chk("resume_no_tick_yet", 32'(bus.TICK), 32'h0);
    cyc(1);
    chk("resume_tick", 32'(bus.TICK), 32'h1);
    chk("resume_time", 32'(now()), 32'h123457);

    // Held minute button gives one edge, no hour carry
    set_time(12, 59, 37);
    bus.INC_MIN = 1'b1;
    cyc(10);
    bus.INC_MIN = 1'b0;
    cyc(1);
    chk("min_held_once", 32'(now()), 32'h120000);

    // Hour button wraps 23 -> 00
    set_time(23, 10, 5);
    press_hour();
    chk("hour_wrap", 32'(now()), 32'h001005);

    // Minute edge collides with tick
    set_time(0, 5, 30);
    bus.RUN = 1'b1;
    cyc(3);
    bus.INC_MIN = 1'b1;
    cyc(1);
    bus.INC_MIN = 1'b0;
    chk("min_collide_time", 32'(now()), 32'h000600);
    chk("min_collide_tick", 32'(bus.TICK), 32'h0);
    cyc(3);
    chk("min_collide_presc", 32'(bus.TICK), 32'h0);
    cyc(1);
    chk("min_collide_next", 32'(now()), 32'h000601);
    chk("min_collide_next_tick", 32'(bus.TICK), 32'h1);

    // Hour edge collides with tick carry
    set_time(22, 59, 59);
    bus.RUN = 1'b1;
    cyc(3);
    bus.INC_HOUR = 1'b1;
    cyc(1);
    bus.INC_HOUR = 1'b0;
    chk("hour_collide_22", 32'(now()), 32'h230000);
    chk("hour_collide_tick", 32'(bus.TICK), 32'h1);

    set_time(23, 59, 59);
    bus.RUN = 1'b1;
    cyc(3);
    bus.INC_HOUR = 1'b1;
    cyc(1);
    bus.INC_HOUR = 1'b0;
    chk("hour_collide_23", 32'(now()), 32'h000000);

    // Both buttons on a tick cycle
    set_time(10, 20, 30);
    bus.RUN = 1'b1;
    cyc(3);
    bus.INC_MIN = 1'b1; bus.INC_HOUR = 1'b1;
    cyc(1);
    bus.INC_MIN = 1'b0; bus.INC_HOUR = 1'b0;
    chk("both_edges_time", 32'(now()), 32'h112100);
    chk("both_edges_tick", 32'(bus.TICK), 32'h0);

    // Asynchronous reset mid-prescaler
    set_time(14, 27, 8);
    chk("preload_142708", 32'(now()), 32'h142708);
    bus.RUN = 1'b1;
    cyc(2);
    RST_N = 1'b0;
    #1;
    chk("async_reset_time", 32'(now()), 32'h000000);
    chk("async_reset_tick", 32'(bus.TICK), 32'h0);
    #1;
    RST_N = 1'b1;
    cyc(3);
    chk("post_reset_no_tick", 32'(bus.TICK), 32'h0);
    cyc(1);
    chk("post_reset_tick", 32'(bus.TICK), 32'h1);
    chk("post_reset_time", 32'(now()), 32'h000001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
